// File: rtl/sdm_1bit_tx.sv
`default_nettype none
// ============================================================================
// Module  : sdm_1bit_tx
// Brief   : Buffered second-order CIFB 1-bit sigma-delta transmitter.
//           Optional LFSR dither on the second integrator: SDM_DITHER_EN.
// Revision: 1.0 - initial release
// ============================================================================
module sdm_1bit_tx #(
    parameter int TICK_DIV = 200
) (
    input  logic               CLK,
    input  logic               RSTb,
    input  logic               enable,
    input  logic signed [15:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               bout,
    output logic               tick,
    output logic               underrun
);

    localparam logic [9:0]         DIV_LAST = 10'(TICK_DIV - 1);
    localparam logic signed [25:0] SAT_MAX  = 26'sd8388607;
    localparam logic signed [25:0] SAT_MIN  = -26'sd8388608;
    localparam logic signed [25:0] FB_POS   = 26'sd32767;
    localparam logic signed [25:0] FB_NEG   = -26'sd32768;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [9:0]         div_cnt;
    logic signed [23:0] i1;
    logic signed [23:0] i2;
    logic signed [15:0] x;
    logic signed [15:0] buf_data;
    logic               full;

    logic               tick_evt;
    logic               wr;
    logic signed [15:0] x_next;
    logic signed [25:0] fb;
    logic signed [25:0] sum1;
    logic signed [25:0] sum2;
    logic signed [23:0] i1_next;
    logic signed [23:0] i2_next;

    function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
        if (v > SAT_MAX) begin
            return 24'sh7FFFFF;
        end else if (v < SAT_MIN) begin
            return 24'sh800000;
        end else begin
            return v[23:0];
        end
    endfunction

    assign s_ready  = !full;
    assign wr       = s_valid && !full;
    // A tick in the same cycle as enable falling is dropped so the buffer survives.
    assign tick_evt = (state == ST_RUN) && enable && (div_cnt == DIV_LAST);

    // An empty buffer at the tick holds the previous sample.
    assign x_next  = full ? buf_data : x;
    assign fb      = bout ? FB_POS : FB_NEG;
    assign sum1    = 26'(i1) + 26'(x_next) - fb;
    assign i1_next = sat24(sum1);
    assign i2_next = sat24(sum2);

`ifdef SDM_DITHER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0]        lfsr;
    logic signed [25:0] dither;

    assign dither = 26'($signed(lfsr[1:0]));
    assign sum2   = 26'(i2) + 26'(i1_next) - fb + dither;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            lfsr <= LFSR_SEED;
        end else if (state == ST_IDLE) begin
            lfsr <= LFSR_SEED;
        end else if (tick_evt) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`else
    assign sum2 = 26'(i2) + 26'(i1_next) - fb;
`endif

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state    <= ST_IDLE;
            div_cnt  <= 10'd0;
            i1       <= 24'sd0;
            i2       <= 24'sd0;
            x        <= 16'sd0;
            buf_data <= 16'sd0;
            full     <= 1'b0;
            bout     <= 1'b0;
            tick     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            tick     <= 1'b0;
            underrun <= 1'b0;

            // The buffer is independent of the run state and is kept across IDLE.
            if (wr) begin
                buf_data <= s_data;
            end
            if (tick_evt && full) begin
                full <= 1'b0;
            end else if (wr) begin
                full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    div_cnt <= 10'd0;
                    i1      <= 24'sd0;
                    i2      <= 24'sd0;
                    x       <= 16'sd0;
                    bout    <= 1'b0;
                    if (enable) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state   <= ST_IDLE;
                        div_cnt <= 10'd0;
                        i1      <= 24'sd0;
                        i2      <= 24'sd0;
                        x       <= 16'sd0;
                        bout    <= 1'b0;
                    end else if (tick_evt) begin
                        div_cnt  <= 10'd0;
                        x        <= x_next;
                        i1       <= i1_next;
                        i2       <= i2_next;
                        bout     <= !i2_next[23];
                        tick     <= 1'b1;
                        underrun <= !full;
                    end else begin
                        div_cnt <= div_cnt + 10'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdm_1bit_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdm_1bit_tx
// Brief   : Directed self-checking bench; one instance at TICK_DIV=200 for
//           divider timing, one at TICK_DIV=4 for modulator/buffer scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdm_1bit_tx;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RSTb;

    logic               slow_en, slow_valid, slow_ready, slow_bout, slow_tick, slow_underrun;
    logic signed [15:0] slow_data;
    logic               fast_en, fast_valid, fast_ready, fast_bout, fast_tick, fast_underrun;
    logic signed [15:0] fast_data;

    int checks = 0;
    int errors = 0;

    sdm_1bit_tx #(.TICK_DIV(200)) dut_slow (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .enable   (slow_en),
        .s_data   (slow_data),
        .s_valid  (slow_valid),
        .s_ready  (slow_ready),
        .bout     (slow_bout),
        .tick     (slow_tick),
        .underrun (slow_underrun)
    );

    sdm_1bit_tx #(.TICK_DIV(4)) dut_fast (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .enable   (fast_en),
        .s_data   (fast_data),
        .s_valid  (fast_valid),
        .s_ready  (fast_ready),
        .bout     (fast_bout),
        .tick     (fast_tick),
        .underrun (fast_underrun)
    );

    task automatic next_edge();
        @(posedge CLK);
        #1;
    endtask

    // Edges until tick is seen high; -1 if the bound expires.
    task automatic count_slow(output int n);
        n = -1;
        for (int i = 1; i <= 1000; i++) begin
            next_edge();
            if (slow_tick) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic count_fast(output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            next_edge();
            if (fast_tick) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic pulse_reset();
        next_edge();
        RSTb = 1'b0;
        next_edge();
        RSTb = 1'b1;
    endtask

    task automatic test_reset();
        int hits;
        #2 RSTb = 1'b0;
        #1;
        checks++;
        if (slow_bout !== 1'b0 || slow_tick !== 1'b0 || slow_underrun !== 1'b0 || slow_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_slow: bout=%b tick=%b underrun=%b ready=%b, required 0 0 0 1",
                     slow_bout, slow_tick, slow_underrun, slow_ready);
        end
        checks++;
        if (fast_bout !== 1'b0 || fast_tick !== 1'b0 || fast_underrun !== 1'b0 || fast_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fast: bout=%b tick=%b underrun=%b ready=%b, required 0 0 0 1",
                     fast_bout, fast_tick, fast_underrun, fast_ready);
        end
        next_edge();
        next_edge();
        RSTb = 1'b1;
        hits = 0;
        for (int i = 0; i < 10000; i++) begin
            next_edge();
            if (slow_tick || slow_bout || slow_underrun || !slow_ready) hits++;
        end
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL idle_quiet: %0d active cycles, required 0", hits);
        end
    endtask

    task automatic test_divider();
        int n;
        slow_en = 1'b1;
        count_slow(n);
        checks++;
        if (n !== 201) begin
            errors++;
            $display("FAIL first_tick: %0d cycles, required 201", n);
        end
        checks++;
        if (slow_underrun !== 1'b1) begin
            errors++;
            $display("FAIL slow_underrun: got %b required 1", slow_underrun);
        end
        next_edge();
        checks++;
        if (slow_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: tick=%b one cycle later, required 0", slow_tick);
        end
        count_slow(n);
        checks++;
        if (n !== 199) begin
            errors++;
            $display("FAIL tick_period1: %0d cycles, required 200", n + 1);
        end
        count_slow(n);
        checks++;
        if (n !== 200) begin
            errors++;
            $display("FAIL tick_period2: %0d cycles, required 200", n);
        end
        slow_en = 1'b0;
    endtask

    // Runs nticks with the sample held and refilled; returns ones count from tick `from`.
    task automatic run_dc(input logic signed [15:0] d, input int nticks, input int from,
                          output int ones, output int unders, output int badper,
                          output logic [7:0] first_bits);
        int n;
        ones = 0; unders = 0; badper = 0; first_bits = 8'd0;
        pulse_reset();
        fast_data  = d;
        fast_valid = 1'b1;
        next_edge();
        fast_en = 1'b1;
        for (int t = 1; t <= nticks; t++) begin
            count_fast(n);
            if (n != ((t == 1) ? 5 : 4)) badper++;
            if (t <= 8) first_bits[t-1] = fast_bout;
            if (t >= from && fast_bout) ones++;
            if (fast_underrun) unders++;
        end
        fast_en    = 1'b0;
        fast_valid = 1'b0;
        next_edge();
    endtask

    task automatic test_dc_levels();
        int ones, unders, badper;
        logic [7:0] fb;
        run_dc(16'sd0, 2000, 1, ones, unders, badper, fb);
        checks++;
        if (fb[6:0] !== 7'b1001011) begin
            errors++;
            $display("FAIL dc0_first7: bits(t7..t1)=%b required 1001011", fb[6:0]);
        end
        checks++;
        if (ones < 990 || ones > 1010) begin
            errors++;
            $display("FAIL dc0_density: ones=%0d of 2000, required 990..1010", ones);
        end
        checks++;
        if (unders !== 0 || badper !== 0) begin
            errors++;
            $display("FAIL dc0_flow: underruns=%0d bad_periods=%0d, required 0 0", unders, badper);
        end
        run_dc(16'sd16384, 2000, 1, ones, unders, badper, fb);
        checks++;
        if (ones < 1490 || ones > 1510) begin
            errors++;
            $display("FAIL dc_half_density: ones=%0d of 2000, required 1490..1510", ones);
        end
        run_dc(16'sh8000, 300, 4, ones, unders, badper, fb);
        checks++;
        if (fb[3:0] !== 4'b0001) begin
            errors++;
            $display("FAIL dcmin_first4: bits(t4..t1)=%b required 0001", fb[3:0]);
        end
        checks++;
        if (ones !== 0) begin
            errors++;
            $display("FAIL dcmin_saturate: ones after tick 4 = %0d, required 0", ones);
        end
    endtask

    task automatic test_underrun();
        int n;
        pulse_reset();
        fast_valid = 1'b0;
        fast_data  = 16'sd0;
        fast_en    = 1'b1;
        count_fast(n);
        checks++;
        if (n !== 5 || fast_underrun !== 1'b1 || fast_bout !== 1'b1) begin
            errors++;
            $display("FAIL underrun_t1: n=%0d underrun=%b bout=%b, required 5 1 1", n, fast_underrun, fast_bout);
        end
        count_fast(n);
        // Write lands exactly on the third tick event.
        next_edge();
        next_edge();
        next_edge();
        fast_data  = 16'sh8000;
        fast_valid = 1'b1;
        next_edge();
        fast_valid = 1'b0;
        checks++;
        if (fast_tick !== 1'b1 || fast_underrun !== 1'b1 || fast_bout !== 1'b0 || fast_ready !== 1'b0) begin
            errors++;
            $display("FAIL overlap: tick=%b underrun=%b bout=%b ready=%b, required 1 1 0 0",
                     fast_tick, fast_underrun, fast_bout, fast_ready);
        end
        count_fast(n);
        checks++;
        if (n !== 4 || fast_underrun !== 1'b0 || fast_bout !== 1'b0 || fast_ready !== 1'b1) begin
            errors++;
            $display("FAIL consume_t4: n=%0d underrun=%b bout=%b ready=%b, required 4 0 0 1",
                     n, fast_underrun, fast_bout, fast_ready);
        end
        count_fast(n);
        checks++;
        if (fast_underrun !== 1'b1 || fast_bout !== 1'b0) begin
            errors++;
            $display("FAIL hold_t5: underrun=%b bout=%b, required 1 0", fast_underrun, fast_bout);
        end
        fast_en = 1'b0;
        next_edge();
    endtask

    task automatic test_enable_drop();
        int n;
        pulse_reset();
        fast_data  = 16'sh8000;
        fast_valid = 1'b1;
        next_edge();
        fast_valid = 1'b0;
        fast_en    = 1'b1;
        count_fast(n);
        fast_valid = 1'b1;
        next_edge();
        fast_valid = 1'b0;
        fast_en    = 1'b0;
        next_edge();
        checks++;
        if (fast_bout !== 1'b0 || fast_tick !== 1'b0 || fast_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: bout=%b tick=%b ready=%b, required 0 0 0", fast_bout, fast_tick, fast_ready);
        end
        fast_en = 1'b1;
        count_fast(n);
        checks++;
        if (n !== 5 || fast_bout !== 1'b1 || fast_underrun !== 1'b0) begin
            errors++;
            $display("FAIL reenable_tick: n=%0d bout=%b underrun=%b, required 5 1 0", n, fast_bout, fast_underrun);
        end
    endtask

    task automatic test_async_reset();
        int n;
        fast_data  = 16'sd5;
        fast_valid = 1'b1;
        next_edge();
        fast_valid = 1'b0;
        RSTb = 1'b0;
        #2;
        checks++;
        if (fast_bout !== 1'b0 || fast_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: bout=%b ready=%b, required 0 1", fast_bout, fast_ready);
        end
        RSTb = 1'b1;
        count_fast(n);
        checks++;
        if (n !== 5 || fast_underrun !== 1'b1 || fast_bout !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_tick: n=%0d underrun=%b bout=%b, required 5 1 1", n, fast_underrun, fast_bout);
        end
        fast_en = 1'b0;
    endtask

    initial begin
        RSTb       = 1'b1;
        slow_en    = 1'b0;
        slow_valid = 1'b0;
        slow_data  = 16'sd0;
        fast_en    = 1'b0;
        fast_valid = 1'b0;
        fast_data  = 16'sd0;
        test_reset();
        test_divider();
        test_dc_levels();
        test_underrun();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdm_1bit_tx.md
SDM_1BIT_TX -- requirements
Module: sdm_1bit_tx

Interface
REQ-001 Parameter TICK_DIV, default 200, is the number of CLK cycles per output bit period; legal range 4..1023.
REQ-002 CLK  input  1  system clock.
REQ-003 RSTb  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  1 = modulator runs; 0 = idle.
REQ-005 s_data  input  16  signed two's-complement sample.
REQ-006 s_valid  input  1  s_data is valid.
REQ-007 s_ready  output  1  the block accepts s_data this cycle.
REQ-008 bout  output  1  1-bit sigma-delta stream, registered.
REQ-009 tick  output  1  one-cycle strobe, high in the cycle bout takes a new value.
REQ-010 underrun  output  1  one-cycle strobe, high when a tick finds no buffered sample.

Function
REQ-011 States: IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0, evaluated every cycle.
REQ-012 In IDLE: divider=0, integrators=0, x=0, bout=0, tick=0, underrun=0, and the buffer keeps its contents.
REQ-013 Divider: 10-bit counter in RUN, 0..TICK_DIV-1, wrapping to 0; a tick event occurs in the cycle the counter equals TICK_DIV-1.
REQ-014 The first tick occurs TICK_DIV cycles after entering RUN; the tick output is registered, so it is high one cycle after the tick event, together with the new bout.
REQ-015 Buffer: one 16-bit holding register plus a full flag; s_ready = !full (combinational from the flag); a write occurs when s_valid && s_ready.
REQ-016 At a tick event with full=1: x <= buffer and full <= 0.
REQ-017 At a tick event with full=0: x keeps its previous value and underrun pulses, aligned with tick.
REQ-018 Tick event and write in the same cycle with full=0: the write fills the buffer; the current tick does not use the new sample, and underrun is flagged.
REQ-019 Tick event with full=1: no write can occur that cycle, because s_ready=0.
REQ-020 Modulator: second-order CIFB with signed 24-bit integrators i1 and i2.
REQ-021 Feedback fb = +32767 when bout=1, else -32768 (the value before the update).
REQ-022 At a tick event: i1' = sat24(i1 + x - fb); i2' = sat24(i2 + i1' - fb); bout' = (i2' >= 0).
REQ-023 sat24 clamps to the range -8388608..+8388607; intermediate sums are at least 26 bits wide, so no wrap-around is permitted.
REQ-024 x is the sample consumed at the same tick event (per REQ-016/017), so latency from buffer to bout is one bit period.
REQ-025 Integrators and bout change only at tick events.

Reset
REQ-026 RSTb=0 forces, asynchronously: state=IDLE, divider=0, i1=i2=0, x=0, buffer=0, full=0, bout=0, tick=0, underrun=0; s_ready is therefore 1.
REQ-027 Reset asserted mid-RUN discards the buffered sample and integrator state.
REQ-028 After RSTb deasserts with enable=1, the first tick follows TICK_DIV cycles later.

Configuration
REQ-029 Macro SDM_DITHER_EN selects dither.
REQ-030 With SDM_DITHER_EN defined: 16-bit Fibonacci LFSR, taps 16/14/13/11, seed 16'hACE1 at reset and in IDLE, advancing once per tick event.
REQ-031 With SDM_DITHER_EN defined: the signed 2-bit value lfsr[1:0] (range -2..+1) is added inside the i2' sum before saturation.
REQ-032 Without SDM_DITHER_EN: no LFSR exists, and behaviour matches REQ-022 exactly.

Verification
REQ-033 Reset and idle: RSTb low, then high with enable=0 -> bout=0, tick=0, s_ready=1, and no tick for 10000 cycles.
REQ-034 Divider: enable=1, TICK_DIV=200 -> first tick 201 cycles after enable rises; ticks repeat every 200 cycles.
REQ-035 DC levels, dither off, 2000 ticks with s_data held and refilled each tick:
  - s_data=0 -> ones density 50% +/-0.5%;
  - s_data=+16384 -> 75% +/-0.5%;
  - s_data=-32768 -> bout=0 after at most 4 ticks.
REQ-036 Underrun and overlap:
  - no write before a tick -> underrun pulses with tick and x is held;
  - write in the same cycle as a tick with an empty buffer -> underrun=1 and full=1 afterwards.
REQ-037 Pilot loopback: feed a 19 kHz sine, amplitude 16000, sampled at 500 kHz with TICK_DIV=200; drive bout into the existing dpll (multiply by 4, divide by 2) -> lock to 38 kHz within 100 ms.
REQ-038 Enable deasserted mid-RUN for 1 cycle -> integrators, x and bout are 0; the buffer is retained; the first new tick comes TICK_DIV cycles after re-enable.
